// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant-form Montgomery datapath and its egress converter.
// Word 0 of a residue is the least-significant word.
package redun_mont_pkg;

  localparam int unsigned NUM_WRDS = 4;
  localparam int unsigned WRD_BITS = 8;

  // Each word carries WRD_BITS payload bits plus one overlapping carry bit.
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StCarry = 4'b0010,
    StSub   = 4'b0100,
    StOut   = 4'b1000
  } redun_to_bin_state_t;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } addsub_op_e;

endpackage

// File: rtl/word_serial_addsub.sv
// One word slice of a serial adder/subtractor; the carry (0..2) or borrow (0..1) is held
// between words. The two bits above the word are exposed so the caller can form top bits.
module word_serial_addsub
  import redun_mont_pkg::*;
#(
  parameter int unsigned Width = WRD_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  addsub_op_e       op_i,
  input  logic [Width+1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] res_o,
  output logic [1:0]       hi_o,
  output logic             neg_o
);

  logic [1:0]       c_q, c_d;
  logic [Width+2:0] sum;

  always_comb begin
    sum   = '0;
    neg_o = 1'b0;
    c_d   = c_q;
    if (op_i == OpAdd) begin
      sum = {1'b0, a_i} + {{(Width + 1){1'b0}}, c_q};
      c_d = sum[Width+1:Width];
    end else begin
      sum   = {1'b0, a_i} - {3'b000, b_i} - {{(Width + 2){1'b0}}, c_q[0]};
      neg_o = sum[Width+2];
      c_d   = {1'b0, neg_o};
    end
    res_o = sum[Width-1:0];
    hi_o  = sum[Width+1:Width];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c_q <= '0;
    end else if (clr_i) begin
      c_q <= '0;
    end else if (en_i) begin
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/redun_to_bin.sv
// Egress converter: resolves redundant carries word-serially, then subtracts the modulus
// pass by pass until the value is canonical, and presents it on a valid/ready handshake.
module redun_to_bin
  import redun_mont_pkg::*;
#(
  parameter int unsigned MAX_SUB_PASSES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  redun0_t                      i_dat,
  input  logic                         i_val,
  output logic                         o_rdy,
  input  logic [NUM_WRDS*WRD_BITS-1:0] i_mod,
  output logic [NUM_WRDS*WRD_BITS-1:0] o_dat,
  output logic                         o_val,
  input  logic                         i_rdy,
  output logic                         o_err
);

  localparam int N     = NUM_WRDS;
  localparam int W     = WRD_BITS;
  localparam int IdxW  = (N > 1) ? $clog2(N) : 1;
  localparam int PassW = $clog2(MAX_SUB_PASSES + 1);

  redun_to_bin_state_t state_q, state_d;

  logic [IdxW-1:0]          idx_q, idx_d;
  logic [PassW-1:0]         passes_q, passes_d;
  redun0_t                  x_q, x_d, x_rot, x_car;
  logic [N-1:0][W-1:0]      m_q, m_d, m_rot, x_out;
  logic [N-2:0][W-1:0]      d_q, d_d, d_shift;
  logic [1:0]               xt_q, xt_d;
  logic                     o_rdy_q, o_rdy_d, o_val_q, o_val_d, o_err_q, o_err_d;
  logic [N*W-1:0]           o_dat_q, o_dat_d;

  logic                     idx_last, accept;
  logic                     au_en, au_clr, au_neg;
  addsub_op_e               au_op;
  logic [W+1:0]             au_a;
  logic [W-1:0]             au_b, au_res;
  logic [1:0]               au_hi;

  assign idx_last = (idx_q == IdxW'(N - 1));
  assign accept   = (state_q == StIdle) && i_val && o_rdy_q;

  // Operands are always taken from word 0 of the rotating stores.
  always_comb begin
    au_en  = (state_q == StCarry) || (state_q == StSub);
    au_clr = accept || (au_en && idx_last);
    au_op  = (state_q == StSub) ? OpSub : OpAdd;
    au_a   = {1'b0, x_q[0]};
    au_b   = '0;
    if (state_q == StSub) begin
      au_a = {(idx_last ? xt_q : 2'b00), x_q[0][W-1:0]};
      au_b = m_q[0];
    end
  end

  word_serial_addsub #(
    .Width(W)
  ) u_addsub (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .en_i  (au_en),
    .clr_i (au_clr),
    .op_i  (au_op),
    .a_i   (au_a),
    .b_i   (au_b),
    .res_o (au_res),
    .hi_o  (au_hi),
    .neg_o (au_neg)
  );

  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      x_rot[i] = x_q[i+1];
      x_car[i] = x_q[i+1];
      m_rot[i] = m_q[i+1];
    end
    x_rot[N-1] = x_q[0];
    x_car[N-1] = {1'b0, au_res};
    m_rot[N-1] = m_q[0];

    for (int i = 0; i < N - 2; i++) begin
      d_shift[i] = d_q[i+1];
    end
    d_shift[N-2] = au_res;

    // End-of-pass value: unchanged x on borrow, otherwise the fresh difference.
    for (int i = 0; i < N - 1; i++) begin
      x_out[i] = au_neg ? x_q[i+1][W-1:0] : d_q[i];
    end
    x_out[N-1] = au_neg ? x_q[0][W-1:0] : au_res;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    passes_d = passes_q;
    x_d      = x_q;
    m_d      = m_q;
    d_d      = d_q;
    xt_d     = xt_q;
    o_rdy_d  = o_rdy_q;
    o_val_d  = o_val_q;
    o_err_d  = o_err_q;
    o_dat_d  = o_dat_q;

    unique case (state_q)
      StIdle: begin
        o_rdy_d = 1'b1;
        if (accept) begin
          o_rdy_d  = 1'b0;
          x_d      = i_dat;
          m_d      = i_mod;
          idx_d    = '0;
          passes_d = '0;
          xt_d     = '0;
          o_err_d  = 1'b0;
          state_d  = StCarry;
        end
      end
      StCarry: begin
        x_d = x_car;
        if (idx_last) begin
          idx_d   = '0;
          xt_d    = au_hi;
          state_d = StSub;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StSub: begin
        m_d = m_rot;
        if (!idx_last) begin
          x_d   = x_rot;
          d_d   = d_shift;
          idx_d = idx_q + 1'b1;
        end else begin
          idx_d = '0;
          for (int i = 0; i < N; i++) begin
            x_d[i] = {1'b0, x_out[i]};
          end
          if (au_neg) begin
            o_val_d = 1'b1;
            o_dat_d = x_out;
            state_d = StOut;
          end else begin
            xt_d     = au_hi;
            passes_d = passes_q + 1'b1;
            if (passes_q == PassW'(MAX_SUB_PASSES - 1)) begin
              o_err_d = 1'b1;
              o_val_d = 1'b1;
              o_dat_d = x_out;
              state_d = StOut;
            end
          end
        end
      end
      StOut: begin
        if (i_rdy) begin
          o_val_d = 1'b0;
          o_rdy_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      passes_q <= '0;
      x_q      <= '0;
      m_q      <= '0;
      d_q      <= '0;
      xt_q     <= '0;
      o_rdy_q  <= 1'b0;
      o_val_q  <= 1'b0;
      o_err_q  <= 1'b0;
      o_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      passes_q <= passes_d;
      x_q      <= x_d;
      m_q      <= m_d;
      d_q      <= d_d;
      xt_q     <= xt_d;
      o_rdy_q  <= o_rdy_d;
      o_val_q  <= o_val_d;
      o_err_q  <= o_err_d;
      o_dat_q  <= o_dat_d;
    end
  end

  assign o_rdy = o_rdy_q;
  assign o_val = o_val_q;
  assign o_err = o_err_q;
  assign o_dat = o_dat_q;

endmodule

// File: tb/tb_redun_to_bin.sv
// Directed and randomized bench for redun_to_bin against an arithmetic reference model.
module tb_redun_to_bin;
  import redun_mont_pkg::*;

  localparam logic [31:0] Mod = 32'hFFFF_FFFB;

  logic        clk = 1'b0;
  logic        rst_n;
  redun0_t     i_dat, i_dat2;
  logic        i_val, i_val2, i_rdy, i_rdy2;
  logic [31:0] i_mod, i_mod2;
  logic        o_rdy, o_val, o_err, o_rdy2, o_val2, o_err2;
  logic [31:0] o_dat, o_dat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  redun_to_bin #(.MAX_SUB_PASSES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat), .i_val(i_val), .o_rdy(o_rdy),
    .i_mod(i_mod), .o_dat(o_dat), .o_val(o_val), .i_rdy(i_rdy), .o_err(o_err)
  );

  redun_to_bin #(.MAX_SUB_PASSES(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat2), .i_val(i_val2), .o_rdy(o_rdy2),
    .i_mod(i_mod2), .o_dat(o_dat2), .o_val(o_val2), .i_rdy(i_rdy2), .o_err(o_err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value of the words, then repeated subtraction bounded by the pass limit.
  function automatic void model(input redun0_t w, input logic [31:0] m, input int maxp,
                                output logic [31:0] res, output int k, output logic err);
    logic [63:0] v;
    int p;
    v = 0;
    for (int i = 0; i < NUM_WRDS; i++) v += 64'(w[i]) << (WRD_BITS * i);
    err = 1'b0;
    k   = 0;
    p   = 0;
    for (int guard = 0; guard < 64; guard++) begin
      if (v < {32'd0, m}) begin
        k = p + 1;
        break;
      end
      v -= {32'd0, m};
      p++;
      if (p == maxp) begin
        err = 1'b1;
        k   = p;
        break;
      end
    end
    res = v[31:0];
  endfunction

  task automatic start_op(input redun0_t w, input logic [31:0] m, input string tag);
    int n;
    i_dat = w;
    i_mod = m;
    i_val = 1'b1;
    n = 0;
    while (!o_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, o_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    i_val = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!o_val && n < 200);
    chk({tag, "_val"}, o_val, 1);
  endtask

  task automatic run_case(input redun0_t w, input logic [31:0] m, input string tag);
    logic [31:0] exp_dat;
    int          k, n;
    logic        exp_err;
    model(w, m, 4, exp_dat, k, exp_err);
    start_op(w, m, tag);
    wait_out(tag, n);
    chk({tag, "_lat"}, n + 1, NUM_WRDS * (1 + k) + 1);
    chk({tag, "_dat"}, o_dat, exp_dat);
    chk({tag, "_err"}, o_err, exp_err);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, o_val, 0);
    chk({tag, "_idle"}, o_rdy, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    redun0_t     w1, w2, w3, wr;
    logic [31:0] m, exp_dat;
    logic        exp_err;
    int          k, n, sel;

    w1 = {9'h012, 9'h034, 9'h055, 9'h178};
    w2 = {9'h0FF, 9'h0FF, 9'h0FF, 9'h0FB};
    w3 = {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
    rst_n = 1'b0; i_val = 1'b0; i_val2 = 1'b0; i_rdy = 1'b1; i_rdy2 = 1'b1;
    i_dat = '0; i_dat2 = '0; i_mod = Mod; i_mod2 = Mod;

    repeat (2) @(negedge clk);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_val", o_val, 0);
    chk("rst_err", o_err, 0);
    chk("rst_dat", o_dat, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_rdy", o_rdy, 1);

    run_case(w1, Mod, "c1");
    run_case(w2, Mod, "eq_mod");
    run_case(w3, Mod, "all_ones");
    run_case('0, Mod, "zero");
    run_case(w1, 32'd0, "mod0");

    // Output held under back-pressure; stray input ignored.
    i_rdy = 1'b0;
    start_op(w1, Mod, "bp");
    wait_out("bp", n);
    chk("bp_lat", n + 1, 9);
    i_dat = w3;
    i_val = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_val", o_val, 1);
      chk("bp_hold_dat", o_dat, 32'h1234_5678);
      chk("bp_hold_rdy", o_rdy, 0);
    end
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_val", o_val, 0);
    chk("bp_rel_rdy", o_rdy, 1);
    run_case(w2, Mod, "bp_next");

    // Reset during the subtract phase.
    start_op(w3, Mod, "rst_mid");
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_val", o_val, 0);
    chk("rst_mid_rdy", o_rdy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_rel", o_rdy, 1);
    run_case(w1, Mod, "after_rst");

    // Pass limit of 2 on the second instance.
    model(w3, Mod, 2, exp_dat, k, exp_err);
    i_dat2 = w3;
    i_val2 = 1'b1;
    n = 0;
    while (!o_rdy2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("lim_rdy", o_rdy2, 1);
    @(posedge clk);
    @(negedge clk);
    i_val2 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!o_val2 && n < 200);
    chk("lim_val", o_val2, 1);
    chk("lim_lat", n + 1, NUM_WRDS * (1 + k) + 1);
    chk("lim_err", o_err2, exp_err);
    chk("lim_dat", o_dat2, exp_dat);
    @(posedge clk);
    @(negedge clk);
    chk("lim_drop", o_val2, 0);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < NUM_WRDS; i++) wr[i] = 9'($urandom_range(0, 511));
      sel = int'($urandom_range(0, 2));
      case (sel)
        0:       m = Mod;
        1:       m = $urandom | 32'h8000_0000;
        default: m = $urandom_range(1, 32'h00FF_FFFF);
      endcase
      run_case(wr, m, $sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
